// File: rtl/usb_spi_arbiter.sv
// Two-requester round-robin arbiter in front of a single SPI mode-0 master.
// Each accepted request becomes one 16-bit frame: command byte, then data byte.
module usb_spi_arbiter #(
    parameter int SCK_DIV = 4
) (
    input  logic        clk_100mhz,
    input  logic        sys_rst,
    input  logic [1:0]  req_valid,
    output logic [1:0]  req_ready,
    input  logic [9:0]  req_addr,
    input  logic [1:0]  req_write,
    input  logic [15:0] req_wdata,
    output logic [1:0]  rsp_valid,
    output logic [7:0]  rsp_status,
    output logic [7:0]  rsp_rdata,
    output logic        busy,
    output logic        spi_ss,
    output logic        spi_sck,
    output logic        spi_mosi,
    input  logic        spi_miso
);
    localparam int HALF = SCK_DIV / 2;
    localparam int CW   = (SCK_DIV > 2) ? $clog2(SCK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, SHIFT, HOLD, GAP} state_t;

    state_t        state, state_nx;
    logic [CW-1:0] cnt;
    logic [3:0]    bit_idx;
    logic [15:0]   tx_sr;
    logic [15:0]   rx_sr;
    logic          pri;
    logic          served;
    logic          grant;
    logic          bit_end;
    logic          half_end;
    logic [4:0]    sel_addr;
    logic          sel_write;
    logic [7:0]    sel_wdata;

    // Both valid: the priority holder wins; otherwise the only valid one wins.
    assign grant     = (req_valid == 2'b11) ? pri : req_valid[1];
    assign sel_addr  = grant ? req_addr[9:5] : req_addr[4:0];
    assign sel_write = req_write[grant];
    assign sel_wdata = grant ? req_wdata[15:8] : req_wdata[7:0];
    assign bit_end   = (cnt == CW'(SCK_DIV - 1));
    assign half_end  = (cnt == CW'(HALF - 1));

    always_comb begin
        req_ready = 2'b00;
        if (state == IDLE && !sys_rst && (|req_valid))
            req_ready[grant] = 1'b1;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:  if (|req_valid) state_nx = SHIFT;
            SHIFT: if (bit_end && bit_idx == 4'd0) state_nx = HOLD;
            HOLD:  if (half_end) state_nx = GAP;
            GAP:   if (half_end) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk_100mhz) begin
        if (sys_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            bit_idx    <= 4'd0;
            tx_sr      <= 16'h0000;
            rx_sr      <= 16'h0000;
            pri        <= 1'b0;
            served     <= 1'b0;
            rsp_status <= 8'h00;
            rsp_rdata  <= 8'h00;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (|req_valid) begin
                        served  <= grant;
                        pri     <= ~grant;
                        tx_sr   <= {sel_addr, 1'b0, sel_write, 1'b0,
                                    sel_write ? sel_wdata : 8'h00};
                        cnt     <= '0;
                        bit_idx <= 4'd15;
                    end
                end
                SHIFT: begin
                    // Sample at the end of the first SCK-high cycle of the bit.
                    if (cnt == CW'(HALF))
                        rx_sr <= {rx_sr[14:0], spi_miso};
                    if (bit_end) begin
                        cnt     <= '0;
                        tx_sr   <= {tx_sr[14:0], 1'b0};
                        bit_idx <= bit_idx - 4'd1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HOLD: begin
                    if (half_end) begin
                        cnt        <= '0;
                        rsp_status <= rx_sr[15:8];
                        rsp_rdata  <= rx_sr[7:0];
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                GAP: begin
                    if (half_end) cnt <= '0;
                    else          cnt <= cnt + CW'(1);
                end
                default: cnt <= '0;
            endcase
        end
    end

    assign busy      = (state != IDLE);
    assign spi_ss    = !(state == SHIFT || state == HOLD);
    assign spi_sck   = (state == SHIFT) && (cnt >= CW'(HALF));
    assign spi_mosi  = (state == SHIFT) && tx_sr[15];
    // GAP always starts with cnt at zero, so its first cycle is the response pulse.
    assign rsp_valid = (state == GAP && cnt == '0) ? (served ? 2'b10 : 2'b01) : 2'b00;

endmodule

// File: tb/tb_usb_spi_arbiter.sv
// Directed bench: driver tasks issue requests and push expectations; monitor and
// SPI slave processes pop and compare whenever the DUT presents a result.
module tb_usb_spi_arbiter;
    localparam int SCK_DIV = 4;
    localparam int HALF    = SCK_DIV / 2;
    localparam int LAT     = 1 + 16 * SCK_DIV + HALF;
    localparam int SS_LOW  = 16 * SCK_DIV + HALF;

    logic        clk_100mhz;
    logic        sys_rst;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [9:0]  req_addr;
    logic [1:0]  req_write;
    logic [15:0] req_wdata;
    logic [1:0]  rsp_valid;
    logic [7:0]  rsp_status;
    logic [7:0]  rsp_rdata;
    logic        busy;
    logic        spi_ss;
    logic        spi_sck;
    logic        spi_mosi;
    logic        spi_miso;

    usb_spi_arbiter #(.SCK_DIV(SCK_DIV)) dut (
        .clk_100mhz(clk_100mhz), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_write(req_write), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_status(rsp_status), .rsp_rdata(rsp_rdata),
        .busy(busy), .spi_ss(spi_ss), .spi_sck(spi_sck), .spi_mosi(spi_mosi),
        .spi_miso(spi_miso)
    );

    // clock / reset
    initial clk_100mhz = 1'b0;
    always #5 clk_100mhz = ~clk_100mhz;

    int cyc = 0;
    always @(posedge clk_100mhz) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;

    logic [17:0] exp_q[$];   // {rsp_valid, status, rdata}
    logic [15:0] mosi_q[$];  // expected MOSI frame
    logic [0:0]  grant_q[$]; // expected winner order

    int   accept_cnt   = 0;
    int   accept_cyc   = 0;
    int   last_rsp_cyc = -1;
    logic gap_check    = 1'b0;
    logic abort_ok     = 1'b0;

    logic [15:0] slave_frame = 16'hFFFF;
    int          s_bits = 0;
    int          s_low  = 0;
    logic [15:0] s_cap  = 16'h0000;
    logic        s_active = 1'b0;
    logic        s_sck_prev = 1'b0;
    logic        p_sck = 1'b0, p_ss = 1'b1, p_mosi = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_err++;
        $display("FAIL %s (cycle %0d)", name, cyc);
    endtask

    // monitor: handshakes, responses and SPI line discipline
    always @(negedge clk_100mhz) begin
        if (!sys_rst) begin
            for (int i = 0; i < 2; i++) begin
                if (req_valid[i] && req_ready[i]) begin
                    if (grant_q.size() == 0) fail_now("unexpected_accept");
                    else check("grant", i, 32'(grant_q.pop_front()));
                    if (gap_check && last_rsp_cyc >= 0)
                        check("accept_gap", cyc - last_rsp_cyc, HALF);
                    accept_cyc = cyc;
                    accept_cnt++;
                end
            end
            if (req_ready != 2'b00) begin
                check("ready_onehot_idle", {30'd0, busy, ($countones(req_ready) > 1)}, 32'd0);
            end
            if (rsp_valid != 2'b00) begin
                if (exp_q.size() == 0) fail_now("unexpected_rsp");
                else check("rsp", {rsp_valid, rsp_status, rsp_rdata}, exp_q.pop_front());
                check("rsp_latency", cyc - accept_cyc, LAT);
                last_rsp_cyc = cyc;
            end
        end
        if (p_sck && spi_sck && (spi_mosi !== p_mosi)) fail_now("mosi_toggle_sck_high");
        if (p_ss && spi_ss && (spi_sck !== p_sck)) fail_now("sck_toggle_ss_high");
        p_sck  = spi_sck;
        p_ss   = spi_ss;
        p_mosi = spi_mosi;
    end

    // SPI slave: shifts MISO on SCK falling, captures MOSI on SCK rising
    always @(negedge clk_100mhz) begin
        if (spi_ss) begin
            if (s_active) begin
                if (s_bits == 16) begin
                    if (mosi_q.size() == 0) fail_now("unexpected_frame");
                    else check("mosi_frame", s_cap, mosi_q.pop_front());
                    check("ss_low_cycles", s_low, SS_LOW);
                end else if (!abort_ok) begin
                    fail_now("partial_frame");
                end
                abort_ok = 1'b0;
                s_active = 1'b0;
            end
            s_bits   = 0;
            s_low    = 0;
            spi_miso = slave_frame[15];
        end else begin
            s_active = 1'b1;
            s_low++;
            if (spi_sck && !s_sck_prev) begin
                s_cap = {s_cap[14:0], spi_mosi};
                s_bits++;
            end
            if (!spi_sck && s_sck_prev && s_bits < 16)
                spi_miso = slave_frame[15 - s_bits];
        end
        s_sck_prev = spi_sck;
    end

    // driver tasks
    task automatic wait_accepts(input int target);
        int t = 0;
        while (accept_cnt < target && t < 1000) begin
            @(negedge clk_100mhz);
            t++;
        end
        if (accept_cnt < target) fail_now("accept_timeout");
        @(negedge clk_100mhz);
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((exp_q.size() != 0 || mosi_q.size() != 0 || busy) && t < 1000) begin
            @(negedge clk_100mhz);
            t++;
        end
        if (t >= 1000) fail_now("idle_timeout");
        @(negedge clk_100mhz);
    endtask

    task automatic check_idle_lines(input string tag);
        check({tag, "_ss"}, spi_ss, 1'b1);
        check({tag, "_sck"}, spi_sck, 1'b0);
        check({tag, "_rsp_valid"}, rsp_valid, 2'b00);
        check({tag, "_ready"}, req_ready, 2'b00);
        check({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        sys_rst   = 1'b1;
        req_valid = 2'b11;
        req_addr  = {5'h1F, 5'h01};
        req_write = 2'b01;
        req_wdata = {8'h00, 8'h55};
        spi_miso  = 1'b1;
        repeat (3) @(negedge clk_100mhz);

        // reset state, with both requesters already valid
        check_idle_lines("reset");
        check("reset_mosi", spi_mosi, 1'b0);
        check("reset_status", rsp_status, 8'h00);
        check("reset_rdata", rsp_rdata, 8'h00);

        // both valid continuously from reset: 0,1,0,1 with HALF-cycle turnaround
        slave_frame = 16'h9966;
        for (int k = 0; k < 4; k++) begin
            grant_q.push_back(k[0]);
            exp_q.push_back(k[0] ? {2'b10, 8'h99, 8'h66} : {2'b01, 8'h99, 8'h66});
            mosi_q.push_back(k[0] ? 16'hF800 : 16'h0A55);
        end
        gap_check    = 1'b1;
        last_rsp_cyc = -1;
        sys_rst      = 1'b0;
        wait_accepts(accept_cnt + 4);
        req_valid = 2'b00;
        wait_idle();
        gap_check = 1'b0;

        // requester 0 write addr 0x14 data 0x01
        slave_frame    = 16'h3CE1;
        req_addr[4:0]  = 5'h14;
        req_write[0]   = 1'b1;
        req_wdata[7:0] = 8'h01;
        grant_q.push_back(1'b0);
        exp_q.push_back({2'b01, 8'h3C, 8'hE1});
        mosi_q.push_back(16'hA201);
        req_valid = 2'b01;
        wait_accepts(accept_cnt + 1);
        req_valid = 2'b00;
        wait_idle();

        // requester 1 read addr 0x13
        slave_frame   = 16'h5AC3;
        req_addr[9:5] = 5'h13;
        req_write[1]  = 1'b0;
        grant_q.push_back(1'b1);
        exp_q.push_back({2'b10, 8'h5A, 8'hC3});
        mosi_q.push_back(16'h9800);
        req_valid = 2'b10;
        wait_accepts(accept_cnt + 1);
        req_valid = 2'b00;
        wait_idle();
        repeat (5) @(negedge clk_100mhz);
        check("hold_status", rsp_status, 8'h5A);
        check("hold_rdata", rsp_rdata, 8'hC3);

        // requester 0 write, aborted by reset during bit 7
        slave_frame    = 16'hFFFF;
        req_addr[4:0]  = 5'h02;
        req_write[0]   = 1'b1;
        req_wdata[7:0] = 8'h77;
        grant_q.push_back(1'b0);
        abort_ok  = 1'b1;
        req_valid = 2'b01;
        wait_accepts(accept_cnt + 1);
        req_valid = 2'b00;
        for (int t = 0; t < 200 && !(s_bits == 8 && !spi_sck && !spi_ss); t++)
            @(negedge clk_100mhz);
        check("abort_at_bit7", s_bits, 8);
        slave_frame = 16'h0FF0;
        req_addr    = {5'h1F, 5'h05};
        req_write   = 2'b00;
        grant_q.push_back(1'b0);
        exp_q.push_back({2'b01, 8'h0F, 8'hF0});
        mosi_q.push_back(16'h2800);
        sys_rst   = 1'b1;
        req_valid = 2'b11;
        @(negedge clk_100mhz);
        check_idle_lines("abort");
        sys_rst = 1'b0;
        wait_accepts(accept_cnt + 1);
        req_valid = 2'b00;
        wait_idle();
        repeat (4) @(negedge clk_100mhz);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/usb_spi_arbiter.md
USB_SPI_ARBITER -- requirements
Module: usb_spi_arbiter

Interface
REQ-001 SHALL have parameter SCK_DIV, default 4: system clocks per SPI SCK period; even, >= 2; HALF = SCK_DIV/2.
REQ-002 SHALL have port clk_100mhz  input  1  system clock; all logic on its rising edge.
REQ-003 SHALL have port sys_rst  input  1  reset; one clock, synchronous, active-high.
REQ-004 SHALL have port req_valid  input  2  per-requester transaction request (bit i = requester i).
REQ-005 SHALL have port req_ready  output  2  per-requester accept; transfer when valid[i] & ready[i].
REQ-006 SHALL have port req_addr  input  10  register address, 5 bits per requester ([4:0] = req 0).
REQ-007 SHALL have port req_write  input  2  1 = register write, 0 = register read.
REQ-008 SHALL have port req_wdata  input  16  write data, 8 bits per requester ([7:0] = req 0).
REQ-009 SHALL have port rsp_valid  output  2  one-cycle completion pulse to the requester served.
REQ-010 SHALL have port rsp_status  output  8  MISO byte captured during the command byte.
REQ-011 SHALL have port rsp_rdata  output  8  MISO byte captured during the data byte.
REQ-012 SHALL have port busy  output  1  high from acceptance until return to IDLE.
REQ-013 SHALL have ports spi_ss (out, 1, active-low select), spi_sck (out, 1), spi_mosi (out, 1), spi_miso (in, 1).

Function
REQ-014 SHALL implement states IDLE -> SHIFT -> HOLD -> GAP -> IDLE.
REQ-015 SHALL, in IDLE with any req_valid high, assert req_ready for exactly one winner, combinationally, and latch its addr/write/wdata on that cycle (cycle T).
REQ-016 SHALL arbitrate round-robin: single valid requester wins; both valid -> requester not served last wins; after reset requester 0 has priority.
REQ-017 SHALL hold req_ready low outside IDLE and for non-winning requesters.
REQ-018 SHALL shift a 16-bit frame MSB first: command byte {addr[4:0], 1'b0, write, 1'b0}, then wdata (write) or 8'h00 (read).
REQ-019 SHALL, in SHIFT starting T+1, drive spi_ss low, with each bit period SCK_DIV cycles: HALF cycles spi_sck low with spi_mosi = current bit, then HALF cycles spi_sck high.
REQ-020 SHALL sample spi_miso on the clk_100mhz edge ending the first spi_sck-high cycle of each bit; bits 15..8 -> rsp_status, bits 7..0 -> rsp_rdata.
REQ-021 SHALL change spi_mosi only while spi_sck is low (SPI mode 0).
REQ-022 SHALL, after bit 0, enter HOLD: spi_sck low, spi_ss low, HALF cycles.
REQ-023 SHALL, at T+1+16*SCK_DIV+HALF, raise spi_ss, pulse rsp_valid for the served requester, present rsp_status/rsp_rdata, and enter GAP.
REQ-024 SHALL keep spi_ss high in GAP for HALF cycles before IDLE; earliest next acceptance is rsp_valid cycle + HALF.
REQ-025 SHALL hold rsp_status/rsp_rdata stable from rsp_valid until the next rsp_valid.
REQ-026 SHALL ignore req_valid changes after acceptance; dropping valid mid-transaction does not abort it.
REQ-027 SHALL treat a valid held through rsp_valid as a new request, eligible under REQ-016.

Reset
REQ-028 SHALL, on sys_rst, clear on the next edge: state IDLE, spi_ss 1, spi_sck 0, spi_mosi 0, rsp_valid 0, rsp_status 0, rsp_rdata 0, busy 0, priority to requester 0; req_ready 0 while sys_rst high.
REQ-029 SHALL, on reset mid-transaction, abort with no rsp_valid and spi_ss high on the following cycle.

Verification
REQ-030 SHALL verify: req 0 write addr 0x14 data 0x01, SCK_DIV=4 -> MOSI 0xA2 then 0x01, spi_ss low 66 cycles, rsp_valid[0] at T+67.
REQ-031 SHALL verify: req 1 read addr 0x13, slave MISO 0x5A then 0xC3 -> MOSI 0x98,0x00; rsp_status 0x5A, rsp_rdata 0xC3, rsp_valid[1] only.
REQ-032 SHALL verify: both valid continuously from reset -> served order 0,1,0,1; each next accept exactly HALF cycles after prior rsp_valid.
REQ-033 SHALL verify: sys_rst asserted at bit 7 -> next cycle spi_ss 1, spi_sck 0, no rsp_valid; subsequent request from req 1 and req 0 together -> req 0 wins.
REQ-034 SHALL verify: spi_mosi never toggles while spi_sck high and spi_sck never toggles while spi_ss high (assertion across all scenarios).
